// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller with IDCODE, bypass and a small CSR access port.
// Rising-edge state/shift logic; tdo is retimed on the falling edge of tck.
module jtag_tap #(
  parameter int unsigned IR_LEN = 6,
  parameter logic [31:0] IDCODE = 32'hCBA3E6FD
) (
  input  logic        tck,
  input  logic        trst_n,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic        tdo_en,
  output logic [1:0]  csr_addr,
  output logic        csr_wr_en,
  output logic [31:0] csr_wdata,
  output logic        csr_rd_en,
  input  logic [31:0] csr_rdata
);

  localparam logic [IR_LEN-1:0] INS_BYPASS   = '1;
  localparam logic [IR_LEN-1:0] INS_IDCODE   = IR_LEN'(6'h3C);
  localparam logic [IR_LEN-1:0] INS_CSR_ADDR = IR_LEN'(6'h06);
  localparam logic [IR_LEN-1:0] INS_CSR_DATA = IR_LEN'(6'h19);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } state_t;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_ADDR, DR_DATA} dr_sel_t;

  state_t            state, nxt;
  dr_sel_t           dr_sel;
  logic [IR_LEN-1:0] ir, ir_sr;
  logic [31:0]       dr_sr;
  logic [2:0]        addr_reg;

  assign csr_addr = addr_reg[2:1];

  always_comb begin
    case (ir)
      INS_IDCODE:   dr_sel = DR_IDCODE;
      INS_CSR_ADDR: dr_sel = DR_ADDR;
      INS_CSR_DATA: dr_sel = DR_DATA;
      INS_BYPASS:   dr_sel = DR_BYPASS;
      default:      dr_sel = DR_BYPASS;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      TLR:      nxt = tms ? TLR    : RTI;
      RTI:      nxt = tms ? SEL_DR : RTI;
      SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   nxt = tms ? SEL_DR : RTI;
      SEL_IR:   nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   nxt = tms ? SEL_DR : RTI;
      default:  nxt = state;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state     <= TLR;
      ir        <= INS_IDCODE;
      ir_sr     <= '0;
      dr_sr     <= '0;
      addr_reg  <= 3'b001;
      csr_wr_en <= 1'b0;
      csr_rd_en <= 1'b0;
      csr_wdata <= '0;
    end else begin
      state     <= nxt;
      csr_wr_en <= 1'b0;
      csr_rd_en <= 1'b0;
      case (state)
        CAP_IR: ir_sr <= IR_LEN'(1);
        SH_IR:  ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
        UPD_IR: ir    <= ir_sr;
        CAP_DR: begin
          case (dr_sel)
            DR_IDCODE: dr_sr <= IDCODE;
            DR_ADDR:   dr_sr <= {29'b0, addr_reg};
            DR_DATA:   dr_sr <= csr_rdata;
            default:   dr_sr <= '0;
          endcase
        end
        SH_DR: begin
          // One shared shift register; tdi enters at the MSB of the selected length.
          case (dr_sel)
            DR_BYPASS: dr_sr[0]   <= tdi;
            DR_ADDR:   dr_sr[2:0] <= {tdi, dr_sr[2:1]};
            default:   dr_sr      <= {tdi, dr_sr[31:1]};
          endcase
        end
        UPD_DR: if (dr_sel == DR_ADDR) addr_reg <= dr_sr[2:0];
        default: ;
      endcase
      // Strobes are registered on entry so they span exactly the CapDR/UpdDR cycle.
      if (nxt == CAP_DR && dr_sel == DR_DATA && addr_reg[0])
        csr_rd_en <= 1'b1;
      if (nxt == UPD_DR && dr_sel == DR_DATA && !addr_reg[0]) begin
        csr_wr_en <= 1'b1;
        csr_wdata <= dr_sr;
      end
      // Entering TLR by tms leaves the same register values as trst_n.
      if (nxt == TLR) begin
        ir        <= INS_IDCODE;
        addr_reg  <= 3'b001;
        csr_wdata <= '0;
      end
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == SH_DR) || (state == SH_IR);
      if (state == SH_IR)      tdo <= ir_sr[0];
      else if (state == SH_DR) tdo <= dr_sr[0];
      else                     tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: IDCODE, IR capture, bypass, CSR write/read,
// TLR via tms and asynchronous reset during a CSR shift.
module tb_jtag_tap;

  logic        tck = 1'b0;
  logic        trst_n, tms, tdi;
  logic        tdo, tdo_en;
  logic [1:0]  csr_addr;
  logic        csr_wr_en, csr_rd_en;
  logic [31:0] csr_wdata, csr_rdata;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned wr_cycles = 0;
  int unsigned rd_cycles = 0;
  logic        tdo_s, tdo_en_s;
  logic [31:0] dout;
  logic [5:0]  cap6;
  logic        en_ok;

  always #10 tck = ~tck;

  jtag_tap #(.IR_LEN(6), .IDCODE(32'hCBA3E6FD)) dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .csr_addr(csr_addr),
    .csr_wr_en(csr_wr_en), .csr_wdata(csr_wdata),
    .csr_rd_en(csr_rd_en), .csr_rdata(csr_rdata)
  );

  always @(negedge tck) begin
    if (csr_wr_en) wr_cycles++;
    if (csr_rd_en) rd_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tck cycle: drive tms/tdi, sample tdo after the falling edge, settle after the rise.
  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(negedge tck); #1;
    tdo_s    = tdo;
    tdo_en_s = tdo_en;
    @(posedge tck); #1;
  endtask

  task automatic ir_shift(input logic [5:0] code, output logic [5:0] cap);
    cap = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(i == 5, code[i]);
      cap[i] = tdo_s;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic dr_cap();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] din, input logic ex,
                          output logic [31:0] dout_o, output logic en_o);
    dout_o = '0;
    en_o   = 1'b1;
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick(ex && (i == n - 1), din[i]);
      dout_o[i] = tdo_s;
      en_o      = en_o & tdo_en_s;
    end
  endtask

  initial begin
    trst_n    = 1'b0;
    tms       = 1'b1;
    tdi       = 1'b0;
    csr_rdata = '0;
    #5;
    check("rst_tdo", tdo, 0);
    check("rst_tdo_en", tdo_en, 0);
    check("rst_wr_en", csr_wr_en, 0);
    check("rst_rd_en", csr_rd_en, 0);
    check("rst_wdata", csr_wdata, 0);
    check("rst_addr", csr_addr, 0);
    @(negedge tck); trst_n = 1'b1;
    @(posedge tck); #1;

    // IDCODE selected out of reset
    tick(1'b0, 1'b0);
    dr_cap();
    check("idc_rd_en", csr_rd_en, 0);
    shift_dr(32, 32'h0, 1'b1, dout, en_ok);
    check("idcode", dout, 32'hCBA3E6FD);
    check("idc_tdo_en", en_ok, 1);
    tick(1'b1, 1'b0);
    check("ex1_tdo_en", tdo_en_s, 0);
    check("ex1_tdo", tdo_s, 0);
    check("idc_no_wr", csr_wr_en, 0);
    tick(1'b0, 1'b0);

    // IR capture pattern, then unknown opcode falls back to bypass
    ir_shift(6'h15, cap6);
    check("ir_capture", cap6, 6'b000001);
    dr_cap();
    shift_dr(8, 32'hB2, 1'b1, dout, en_ok);
    check("bypass", dout, 32'h64);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // CSR write to address 2
    ir_shift(6'h06, cap6);
    dr_cap();
    shift_dr(3, 32'h4, 1'b1, dout, en_ok);
    check("addr_cap_rst", dout, 32'h1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("addr_wr2", csr_addr, 2);
    ir_shift(6'h19, cap6);
    csr_rdata = 32'hA5A50F0F;
    dr_cap();
    check("wr_no_rd", csr_rd_en, 0);
    shift_dr(32, 32'hDEADBEEF, 1'b1, dout, en_ok);
    check("wr_capture", dout, 32'hA5A50F0F);
    tick(1'b1, 1'b0);
    check("wr_en_upd", csr_wr_en, 1);
    check("wr_wdata", csr_wdata, 32'hDEADBEEF);
    check("wr_addr", csr_addr, 2);
    tick(1'b0, 1'b0);
    check("wr_en_drop", csr_wr_en, 0);
    check("wr_cycles1", wr_cycles, 1);

    // CSR read from address 1
    ir_shift(6'h06, cap6);
    dr_cap();
    shift_dr(3, 32'h3, 1'b1, dout, en_ok);
    check("addr_cap_prev", dout, 32'h4);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("addr_rd1", csr_addr, 1);
    ir_shift(6'h19, cap6);
    csr_rdata = 32'h12345678;
    dr_cap();
    check("rd_en_cap", csr_rd_en, 1);
    check("rd_addr", csr_addr, 1);
    shift_dr(32, 32'h0, 1'b0, dout, en_ok);
    check("rd_data", dout, 32'h12345678);
    check("rd_en_drop", csr_rd_en, 0);
    check("rd_cycles1", rd_cycles, 1);

    // Five tms=1 from ShDR passes UpdDR with rw=1 and lands in TLR
    repeat (5) tick(1'b1, 1'b0);
    check("tlr_addr", csr_addr, 0);
    check("tlr_wdata", csr_wdata, 0);
    check("tlr_no_wr", wr_cycles, 1);
    check("tlr_tdo_en", tdo_en, 0);
    tick(1'b0, 1'b0);
    dr_cap();
    shift_dr(32, 32'h0, 1'b1, dout, en_ok);
    check("tlr_idcode", dout, 32'hCBA3E6FD);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // trst_n asserted mid CSR_DATA shift with a write pending
    ir_shift(6'h06, cap6);
    dr_cap();
    shift_dr(3, 32'h6, 1'b1, dout, en_ok);
    check("tlr_addr_cap", dout, 32'h1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("addr_wr3", csr_addr, 3);
    ir_shift(6'h19, cap6);
    dr_cap();
    check("rst_no_rd", csr_rd_en, 0);
    shift_dr(16, 32'hFFFF, 1'b0, dout, en_ok);
    check("rst_partial", dout, 32'h5678);
    trst_n = 1'b0;
    #2;
    check("mid_tdo", tdo, 0);
    check("mid_tdo_en", tdo_en, 0);
    check("mid_wr_en", csr_wr_en, 0);
    check("mid_rd_en", csr_rd_en, 0);
    check("mid_wdata", csr_wdata, 0);
    check("mid_addr", csr_addr, 0);
    tms = 1'b1;
    @(negedge tck); trst_n = 1'b1;
    @(posedge tck); #1;
    tick(1'b0, 1'b0);
    dr_cap();
    shift_dr(32, 32'h0, 1'b1, dout, en_ok);
    check("mid_idcode", dout, 32'hCBA3E6FD);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("final_wr_cycles", wr_cycles, 1);
    check("final_rd_cycles", rd_cycles, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
JTAG_TAP -- requirements
Module: jtag_tap

Interface
REQ-001 Parameter IR_LEN, default 6: instruction register width in bits.
REQ-002 Parameter IDCODE, default 32'hCBA3E6FD: IDCODE register value; bit 0 SHALL be 1.
REQ-003 Instruction encodings SHALL be BYPASS='1 (6'h3F), IDCODE=6'h3C, CSR_ADDR=6'h06, CSR_DATA=6'h19.
REQ-004 tck  in  1  sole clock; all state updates on rising edge except REQ-021.
REQ-005 trst_n  in  1  asynchronous, active-low reset.
REQ-006 tms  in  1  TAP mode select, sampled on tck rise.
REQ-007 tdi  in  1  serial data in, sampled on tck rise.
REQ-008 tdo  out  1  serial data out.
REQ-009 tdo_en  out  1  high while tdo carries valid shift data.
REQ-010 csr_addr  out  2  selected CSR address.
REQ-011 csr_wr_en  out  1  single-tck write strobe.
REQ-012 csr_wdata  out  32  write data, valid while csr_wr_en is high.
REQ-013 csr_rd_en  out  1  single-tck read strobe.
REQ-014 csr_rdata  in  32  read data, sampled on the same edge as csr_rd_en.

Function
REQ-015 The TAP controller SHALL implement the 16 IEEE 1149.1 states and transitions: TLR(tms0->RTI), RTI(1->SelDR), SelDR(0->CapDR, 1->SelIR), CapDR(0->ShDR, 1->Ex1DR), ShDR(1->Ex1DR), Ex1DR(0->PauseDR, 1->UpdDR), PauseDR(1->Ex2DR), Ex2DR(0->ShDR, 1->UpdDR), UpdDR(0->RTI, 1->SelDR), SelIR(0->CapIR, 1->TLR); the IR branch mirrors the DR branch; every unlisted case holds state.
REQ-016 Five consecutive tck rises with tms=1 SHALL reach TLR from any state.
REQ-017 In TLR, IR SHALL hold IDCODE; csr address register SHALL hold 3'b001 (address 0, read).
REQ-018 CapIR SHALL load the IR shift register with 6'b000001; ShIR SHALL shift right, tdi into the MSB; UpdIR SHALL copy the shift register to IR.
REQ-019 DR selection by IR: BYPASS -> 1-bit bypass; IDCODE -> 32-bit; CSR_ADDR -> 3-bit; CSR_DATA -> 32-bit; any other code SHALL select bypass.
REQ-020 CapDR SHALL load: bypass 0; IDCODE value; CSR_ADDR current address register; CSR_DATA csr_rdata. ShDR SHALL shift right, LSB first, tdi into the MSB of the selected register.
REQ-021 tdo SHALL be registered on the falling edge of tck from the selected shift register LSB; tdo_en SHALL be high on the falling edge following entry to ShDR/ShIR and low otherwise; tdo SHALL be 0 when tdo_en is low.
REQ-022 UpdDR with IR=CSR_ADDR SHALL load the 3-bit address register; csr_addr = bits[2:1]; bit 0 = rw (1 = read).
REQ-023 csr_rd_en SHALL be high for exactly the tck cycle in CapDR when IR=CSR_DATA and rw=1.
REQ-024 csr_wr_en SHALL be high for exactly the tck cycle in UpdDR when IR=CSR_DATA and rw=0, with csr_wdata = the 32-bit shift register; rw=1 SHALL suppress the write.
REQ-025 Pause states SHALL preserve shift-register contents; Ex2->Sh SHALL resume shifting without recapture.
REQ-026 Registers not selected SHALL not change during shift or update.

Reset
REQ-027 trst_n low SHALL immediately force: state TLR, IR IDCODE, address register 3'b001, tdo 0, tdo_en 0, csr_wr_en 0, csr_rd_en 0, csr_wdata 0.
REQ-028 Reset asserted mid-shift SHALL abort the shift without generating csr_wr_en.
REQ-029 The TLR reset path (REQ-016) SHALL produce the same register values as trst_n, except tdo/tdo_en timing per REQ-021.

Verification
REQ-030 Release trst_n, then TLR->CapDR, shift 32 -> tdo LSB-first stream equals 32'hCBA3E6FD.
REQ-031 CapIR, shift 6 bits -> tdo stream 1,0,0,0,0,0; after UpdIR with 6'h15, DR shift -> tdi-to-tdo delay of one bit (bypass).
REQ-032 Write address 3'b100, then CSR_DATA shift 32'hDEADBEEF -> one-cycle csr_wr_en at UpdDR, csr_addr=2, csr_wdata=32'hDEADBEEF.
REQ-033 Address 3'b011, csr_rdata=32'h12345678 -> csr_rd_en one cycle in CapDR, csr_addr=1, tdo stream 32'h12345678, no csr_wr_en.
REQ-034 From ShDR, hold tms=1 for 5 tck -> TLR, IR=IDCODE, no csr_wr_en pulse.
REQ-035 trst_n low during CSR_DATA ShDR -> all outputs at REQ-027 values, no strobe.
